// File: rtl/rob_buffer_pkg.sv
// rtl/rob_buffer_pkg.sv - shared widths, entry payload type and operand-read helper for the reorder buffer
package rob_buffer_pkg;

  localparam int ROB_ADDR_WIDTH = 4;
  localparam int ROB_DEPTH      = 1 << ROB_ADDR_WIDTH;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int EXC_WIDTH      = 8;

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_id_t;
  typedef logic [ROB_ADDR_WIDTH:0]   rob_count_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [EXC_WIDTH-1:0]      exc_t;

  localparam rob_count_t ROB_COUNT_FULL = rob_count_t'(ROB_DEPTH);

  // Payload of one ROB slot; valid/done live in separate vectors so they can be cleared on flush.
  typedef struct packed {
    logic      reg_we;
    reg_addr_t reg_addr;
    data_t     data;
    exc_t      exc;
    data_t     pc;
  } rob_entry_t;

  // Operand lookup: returns {ready, data}. A writeback landing this cycle is forwarded.
  function automatic logic [DATA_WIDTH:0] rob_operand_read(
    input logic  entry_valid,
    input logic  entry_done,
    input data_t entry_data,
    input logic  wb_match,
    input data_t wb_data
  );
    logic [DATA_WIDTH:0] res;
    res = '0;
    if (entry_valid) begin
      if (wb_match) begin
        res = {1'b1, wb_data};
      end else if (entry_done) begin
        res = {1'b1, entry_data};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rob_buffer_if.sv
// rtl/rob_buffer_if.sv - dispatch/writeback/commit bus of the reorder buffer (read ports under ROB_OPERAND_READ_EN)
interface rob_buffer_if;
  import rob_buffer_pkg::*;

  logic      dispatch_valid;
  logic      dispatch_ready;
  rob_id_t   dispatch_rob_id;
  logic      dispatch_reg_write_en;
  reg_addr_t dispatch_reg_write_addr;
  exc_t      dispatch_exception_type;
  data_t     dispatch_pc;

  logic      wb_valid;
  rob_id_t   wb_rob_id;
  data_t     wb_data;
  exc_t      wb_exception_type;

  logic      commit_valid;
  logic      commit_ready;
  logic      commit_reg_write_en;
  reg_addr_t commit_reg_write_addr;
  data_t     commit_data;
  exc_t      commit_exception_type;
  data_t     commit_pc;
  rob_id_t   commit_rob_id;

`ifdef ROB_OPERAND_READ_EN
  rob_id_t   read_rob_id_1;
  rob_id_t   read_rob_id_2;
  logic      read_ready_1;
  logic      read_ready_2;
  data_t     read_data_1;
  data_t     read_data_2;
`endif

  modport slave (
    input  dispatch_valid, dispatch_reg_write_en, dispatch_reg_write_addr,
           dispatch_exception_type, dispatch_pc,
           wb_valid, wb_rob_id, wb_data, wb_exception_type,
           commit_ready,
`ifdef ROB_OPERAND_READ_EN
    input  read_rob_id_1, read_rob_id_2,
    output read_ready_1, read_ready_2, read_data_1, read_data_2,
`endif
    output dispatch_ready, dispatch_rob_id,
           commit_valid, commit_reg_write_en, commit_reg_write_addr,
           commit_data, commit_exception_type, commit_pc, commit_rob_id
  );

  modport master (
    output dispatch_valid, dispatch_reg_write_en, dispatch_reg_write_addr,
           dispatch_exception_type, dispatch_pc,
           wb_valid, wb_rob_id, wb_data, wb_exception_type,
           commit_ready,
`ifdef ROB_OPERAND_READ_EN
    output read_rob_id_1, read_rob_id_2,
    input  read_ready_1, read_ready_2, read_data_1, read_data_2,
`endif
    input  dispatch_ready, dispatch_rob_id,
           commit_valid, commit_reg_write_en, commit_reg_write_addr,
           commit_data, commit_exception_type, commit_pc, commit_rob_id
  );

endinterface

// File: rtl/rob_ptr_counter.sv
// rtl/rob_ptr_counter.sv - wrapping circular-buffer pointer with increment and synchronous clear
module rob_ptr_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  // Clear wins over increment; natural overflow gives the modulo-depth wrap.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_buffer.sv
// rtl/rob_buffer.sv - in-order-retire reorder buffer; ROB_OPERAND_READ_EN adds two operand read ports
module rob_buffer
  import rob_buffer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  rob_buffer_if.slave  bus,
  output logic         empty,
  output logic         full
);

  rob_id_t    w_head;
  rob_id_t    w_tail;
  rob_count_t r_count;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  rob_entry_t r_entry [ROB_DEPTH];

  logic w_clear;
  logic w_full;
  logic w_dispatch_fire;
  logic w_commit_valid;
  logic w_commit_fire;
  logic w_wb_hit;

  assign w_clear         = rst | flush;
  assign w_full          = (r_count == ROB_COUNT_FULL);
  // No bypass from a same-cycle commit: a full ROB refuses dispatch even while retiring.
  assign w_dispatch_fire = bus.dispatch_valid & ~w_full;
  assign w_commit_valid  = r_valid[w_head] & r_done[w_head];
  assign w_commit_fire   = w_commit_valid & bus.commit_ready;
  // Uses the registered valid, so a writeback to a slot being allocated this cycle is dropped.
  assign w_wb_hit        = bus.wb_valid & r_valid[bus.wb_rob_id];

  rob_ptr_counter #(.WIDTH(ROB_ADDR_WIDTH)) u_head (
    .clk   (clk),
    .i_clr (w_clear),
    .i_inc (w_commit_fire),
    .o_ptr (w_head)
  );

  rob_ptr_counter #(.WIDTH(ROB_ADDR_WIDTH)) u_tail (
    .clk   (clk),
    .i_clr (w_clear),
    .i_inc (w_dispatch_fire),
    .o_ptr (w_tail)
  );

  // Occupancy: dispatch and commit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_count <= '0;
    end else begin
      case ({w_dispatch_fire, w_commit_fire})
        2'b10:   r_count <= r_count + rob_count_t'(1);
        2'b01:   r_count <= r_count - rob_count_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry status; head and tail only coincide when empty or full, so the commit clear and allocation never collide.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_wb_hit) begin
        r_done[bus.wb_rob_id] <= 1'b1;
      end
      if (w_commit_fire) begin
        r_valid[w_head] <= 1'b0;
        r_done[w_head]  <= 1'b0;
      end
      if (w_dispatch_fire) begin
        r_valid[w_tail] <= 1'b1;
        r_done[w_tail]  <= (bus.dispatch_exception_type != '0);
      end
    end
  end

  // Payload RAM: cleared by reset only, left stale on flush since valid gates every use.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (!flush) begin
      if (w_wb_hit) begin
        r_entry[bus.wb_rob_id].data <= bus.wb_data;
        r_entry[bus.wb_rob_id].exc  <= r_entry[bus.wb_rob_id].exc | bus.wb_exception_type;
      end
      if (w_dispatch_fire) begin
        r_entry[w_tail] <= '{reg_we:   bus.dispatch_reg_write_en,
                             reg_addr: bus.dispatch_reg_write_addr,
                             data:     '0,
                             exc:      bus.dispatch_exception_type,
                             pc:       bus.dispatch_pc};
      end
    end
  end

  assign bus.dispatch_ready        = ~w_full;
  assign bus.dispatch_rob_id       = w_tail;
  assign bus.commit_valid          = w_commit_valid;
  assign bus.commit_rob_id         = w_head;
  assign bus.commit_reg_write_en   = w_commit_valid ? r_entry[w_head].reg_we   : 1'b0;
  assign bus.commit_reg_write_addr = w_commit_valid ? r_entry[w_head].reg_addr : '0;
  assign bus.commit_data           = w_commit_valid ? r_entry[w_head].data     : '0;
  assign bus.commit_exception_type = w_commit_valid ? r_entry[w_head].exc      : '0;
  assign bus.commit_pc             = w_commit_valid ? r_entry[w_head].pc       : '0;
  assign empty                     = (r_count == '0);
  assign full                      = w_full;

`ifdef ROB_OPERAND_READ_EN
  logic [DATA_WIDTH:0] w_read_1;
  logic [DATA_WIDTH:0] w_read_2;

  // Operand lookups for ID, forwarding a same-cycle writeback to the requested entry.
  always_comb begin
    w_read_1 = rob_operand_read(r_valid[bus.read_rob_id_1], r_done[bus.read_rob_id_1],
                                r_entry[bus.read_rob_id_1].data,
                                bus.wb_valid && (bus.wb_rob_id == bus.read_rob_id_1), bus.wb_data);
    w_read_2 = rob_operand_read(r_valid[bus.read_rob_id_2], r_done[bus.read_rob_id_2],
                                r_entry[bus.read_rob_id_2].data,
                                bus.wb_valid && (bus.wb_rob_id == bus.read_rob_id_2), bus.wb_data);
  end

  assign bus.read_ready_1 = w_read_1[DATA_WIDTH];
  assign bus.read_data_1  = w_read_1[DATA_WIDTH-1:0];
  assign bus.read_ready_2 = w_read_2[DATA_WIDTH];
  assign bus.read_data_2  = w_read_2[DATA_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_rob_buffer.sv
// tb/tb_rob_buffer.sv - scoreboard bench for rob_buffer
module tb_rob_buffer;
  import rob_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic empty;
  logic full;

  rob_buffer_if bus();

  rob_buffer u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    logic [31:0] we;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] exc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid          = 1'b0;
    bus.dispatch_reg_write_en   = 1'b0;
    bus.dispatch_reg_write_addr = '0;
    bus.dispatch_exception_type = '0;
    bus.dispatch_pc             = '0;
    bus.wb_valid                = 1'b0;
    bus.wb_rob_id               = '0;
    bus.wb_data                 = '0;
    bus.wb_exception_type       = '0;
  endtask

  task automatic drive_dispatch(input logic [31:0] pc, input logic we, input logic [4:0] addr,
                                input logic [7:0] exc);
    bus.dispatch_valid          = 1'b1;
    bus.dispatch_pc             = pc;
    bus.dispatch_reg_write_en   = we;
    bus.dispatch_reg_write_addr = addr;
    bus.dispatch_exception_type = exc;
  endtask

  task automatic drive_wb(input logic [3:0] id, input logic [31:0] data, input logic [7:0] exc);
    bus.wb_valid          = 1'b1;
    bus.wb_rob_id         = id;
    bus.wb_data           = data;
    bus.wb_exception_type = exc;
  endtask

  task automatic push_exp(input int id, input int we, input int addr, input logic [31:0] pc,
                          input logic [31:0] data, input logic [31:0] exc);
    exp_t e;
    e.id = id; e.we = we; e.addr = addr; e.pc = pc; e.data = data; e.exc = exc;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every retiring commit must match the next expected record in program order.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.commit_valid === 1'b1 && bus.commit_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got id %0d pc 0x%0h expected no commit",
                 bus.commit_rob_id, bus.commit_pc);
      end else begin
        e = exp_q.pop_front();
        check("commit_rob_id", 32'(bus.commit_rob_id), e.id);
        check("commit_we", 32'(bus.commit_reg_write_en), e.we);
        check("commit_addr", 32'(bus.commit_reg_write_addr), e.addr);
        check("commit_pc", bus.commit_pc, e.pc);
        check("commit_data", bus.commit_data, e.data);
        check("commit_exc", 32'(bus.commit_exception_type), e.exc);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    bus.commit_ready = 1'b1;
`ifdef ROB_OPERAND_READ_EN
    bus.read_rob_id_1 = '0;
    bus.read_rob_id_2 = '0;
`endif
    tick();
    tick();
    rst = 1'b0;

    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ready", 32'(bus.dispatch_ready), 1);
    check("rst_disp_id", 32'(bus.dispatch_rob_id), 0);
    check("rst_commit_valid", 32'(bus.commit_valid), 0);
    check("rst_commit_data", bus.commit_data, 0);
    check("rst_commit_pc", bus.commit_pc, 0);

    // Out-of-order completion, in-order retirement.
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 8'h00);
      check("disp_id_seq", 32'(bus.dispatch_rob_id), 32'(i));
      tick();
    end
    idle();
    check("three_not_empty", 32'(empty), 0);
    check("three_no_commit", 32'(bus.commit_valid), 0);
    push_exp(0, 1, 1, 32'h100, 32'h11, 0);
    push_exp(1, 1, 2, 32'h104, 32'h33, 0);
    push_exp(2, 1, 3, 32'h108, 32'h22, 0);
    drive_wb(4'd2, 32'h22, 8'h00);
    tick();
    check("cv_after_wb2", 32'(bus.commit_valid), 0);
    drive_wb(4'd0, 32'h11, 8'h00);
    tick();
    check("cv_after_wb0", 32'(bus.commit_valid), 1);
    drive_wb(4'd1, 32'h33, 8'h00);
    tick();
    idle();
    repeat (3) tick();
    check("ooo_drained_empty", 32'(empty), 1);

    // Fill to 16, refuse dispatch while committing from full, then wrap to id 0.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      drive_dispatch(32'h200 + 32'(4 * i), 1'(i & 1), 5'(i), 8'h00);
      tick();
    end
    idle();
    check("full_flag", 32'(full), 1);
    check("full_ready", 32'(bus.dispatch_ready), 0);
    check("full_not_empty", 32'(empty), 0);
    check("full_tail_wrapped", 32'(bus.dispatch_rob_id), 0);
    push_exp(0, 0, 0, 32'h200, 32'hA0, 0);
    drive_wb(4'd0, 32'hA0, 8'h00);
    tick();
    idle();
    drive_dispatch(32'h500, 1'b1, 5'd9, 8'h00);
    check("full_commit_cv", 32'(bus.commit_valid), 1);
    check("full_commit_ready", 32'(bus.dispatch_ready), 0);
    tick();
    check("after_commit_full", 32'(full), 0);
    check("after_commit_ready", 32'(bus.dispatch_ready), 1);
    check("wrap_disp_id", 32'(bus.dispatch_rob_id), 0);
    tick();
    idle();
    check("full_again", 32'(full), 1);

    // Stalled commit: head held with stable outputs, no pointer motion.
    bus.commit_ready = 1'b0;
    drive_wb(4'd1, 32'hB1, 8'h02);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      check("stall_cv", 32'(bus.commit_valid), 1);
      check("stall_id", 32'(bus.commit_rob_id), 1);
      check("stall_data", bus.commit_data, 32'hB1);
      check("stall_exc", 32'(bus.commit_exception_type), 32'h02);
      check("stall_pc", bus.commit_pc, 32'h204);
      check("stall_full", 32'(full), 1);
      tick();
    end
    push_exp(1, 1, 1, 32'h204, 32'hB1, 32'h02);
    bus.commit_ready = 1'b1;
    tick();
    check("post_stall_cv", 32'(bus.commit_valid), 0);
    check("post_stall_full", 32'(full), 0);

    // Flush with live entries and a same-cycle dispatch and writeback.
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      drive_dispatch(32'h300 + 32'(4 * i), 1'b1, 5'(i), 8'h00);
      tick();
    end
    idle();
    flush = 1'b1;
    drive_dispatch(32'h3FC, 1'b1, 5'd7, 8'h00);
    drive_wb(4'd0, 32'h55, 8'h00);
    tick();
    flush = 1'b0;
    idle();
    check("flush_empty", 32'(empty), 1);
    check("flush_full", 32'(full), 0);
    check("flush_cv", 32'(bus.commit_valid), 0);
    check("flush_tail", 32'(bus.dispatch_rob_id), 0);
    check("flush_head", 32'(bus.commit_rob_id), 0);
    drive_wb(4'd3, 32'h77, 8'h00);
    tick();
    idle();
    tick();
    check("stale_wb_cv", 32'(bus.commit_valid), 0);
    check("stale_wb_empty", 32'(empty), 1);

    // Exception at dispatch completes the entry without a writeback.
    push_exp(0, 1, 5, 32'h400, 32'h0, 32'h04);
    drive_dispatch(32'h400, 1'b1, 5'd5, 8'h04);
    check("exc_disp_id", 32'(bus.dispatch_rob_id), 0);
    tick();
    idle();
    check("exc_cv", 32'(bus.commit_valid), 1);
    check("exc_type", 32'(bus.commit_exception_type), 32'h04);
    tick();
    check("exc_empty", 32'(empty), 1);

    tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- Reorder buffer sitting directly downstream of the ID→ROB pipeline register.
- Accepts one decoded instruction per cycle, allocates a circular entry and returns its ROB id.
- Collects one functional-unit writeback per cycle.
- Retires completed instructions strictly in program order to the commit/regfile stage.

Parameters:
ROB_ADDR_WIDTH, 4, entry index width; depth = 2**ROB_ADDR_WIDTH (16)
REG_ADDR_WIDTH, 5, architectural register address width
DATA_WIDTH, 32, data/PC width
EXC_WIDTH, 8, exception type width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  discard all entries (exception/mispredict recovery)
dispatch_valid  in  1  ID stage presents an instruction
dispatch_ready  out  1  entry free; a dispatch is accepted on dispatch_valid && dispatch_ready
dispatch_rob_id  out  ROB_ADDR_WIDTH  id given to the accepted instruction (current tail)
dispatch_reg_write_en  in  1  destination write enable
dispatch_reg_write_addr  in  REG_ADDR_WIDTH  destination register
dispatch_exception_type  in  EXC_WIDTH  exception detected at or before ID; nonzero marks the entry done
dispatch_pc  in  DATA_WIDTH  instruction PC
wb_valid  in  1  functional-unit result valid
wb_rob_id  in  ROB_ADDR_WIDTH  entry that completed
wb_data  in  DATA_WIDTH  result value
wb_exception_type  in  EXC_WIDTH  exception raised in execution; ORed into the entry
commit_valid  out  1  head entry valid and done
commit_ready  in  1  downstream accepts the commit
commit_reg_write_en  out  1  head entry write enable
commit_reg_write_addr  out  REG_ADDR_WIDTH  head entry destination
commit_data  out  DATA_WIDTH  head entry result
commit_exception_type  out  EXC_WIDTH  head entry exception
commit_pc  out  DATA_WIDTH  head entry PC
commit_rob_id  out  ROB_ADDR_WIDTH  head index
empty  out  1  count == 0
full  out  1  count == depth

Behaviour:
- State: head, tail (ROB_ADDR_WIDTH each), count (ROB_ADDR_WIDTH+1). Per entry: valid, done, reg_we, reg_addr, data, exc, pc.
- rst (synchronous):
  - head, tail, count = 0; all valid/done = 0.
  - Outputs after reset: empty=1, full=0, dispatch_ready=1, dispatch_rob_id=0, commit_valid=0.
  - All commit_* data outputs are 0 while commit_valid=0 (gated).
- Priority: rst > flush > normal operation. flush has the same effect as rst except entry payload RAM is not cleared. flush overrides any same-cycle dispatch, writeback or commit.
- dispatch_ready = !full, computed from the registered count only. There is no same-cycle bypass from a commit, so a full ROB refuses dispatch even while committing.
- Accepted dispatch:
  - Entry[tail] gets valid=1, payload written.
  - done=1 if dispatch_exception_type != 0, else done=0.
  - tail wraps modulo depth.
- Writeback: on wb_valid, if entry[wb_rob_id].valid:
  - done=1, data=wb_data, exc |= wb_exception_type.
  - Writeback to an invalid entry is silently ignored.
  - A writeback to an entry dispatched in the same cycle cannot occur; the entry is not yet valid, so the writeback is ignored.
- Commit outputs are combinational from entry[head]. commit_valid = valid && done.
- Commit fires when commit_valid && commit_ready:
  - entry[head].valid and done cleared; head wraps.
  - Commit still fires when exc is nonzero; the downstream stage raises flush.
- Latencies:
  - Writeback→commit_valid: 1 cycle.
  - Dispatch→commit with exception at dispatch: 1 cycle.
  - Minimum dispatch→commit for a normal instruction: 2 cycles.
- Simultaneous dispatch and commit: count unchanged; both pointers advance. The same index cannot be both head and tail unless the ROB is empty (no commit possible) or full (no dispatch accepted).
- Writeback to head in the same cycle as a stalled commit (commit_ready=0): the update is applied; commit_valid stays high next cycle.
- Wrap-around: after 16 allocations tail=0; ids reuse only after commit.
- count: +1 on dispatch only, −1 on commit only.

Optional Feature:
ROB_OPERAND_READ_EN
- Defined: adds two read ports for resolving operand references from ID:
  - inputs read_rob_id_1/2 (ROB_ADDR_WIDTH);
  - outputs read_ready_1/2 (1) and read_data_1/2 (DATA_WIDTH).
- Read is combinational. ready = entry valid && done, or same-cycle wb_valid && wb_rob_id match, in which case wb_data is bypassed.
- Invalid entry: ready=0, data=0.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared header rob.v: ROB_ADDR_WIDTH, ROB_DEPTH, `ROB_ADDR_BUS`. EXC_TYPE width reuses the existing bus definitions.
- One natural sub-module: rob_ptr_counter, a wrapping pointer with increment and synchronous clear. Instantiate it twice (head, tail).

Test Plan:
- Reset then 3 dispatches (pc 0x100/0x104/0x108) → dispatch_rob_id 0,1,2; count=3; commit_valid=0.
- Writebacks in order id2 (data 0x22), id0 (0x11), id1 → commits occur in order 0,1,2 with data 0x11, result of id1, 0x22; commit_valid rises 1 cycle after wb of id0.
- 16 dispatches with no writeback → full=1, dispatch_ready=0. Complete id0 and commit with simultaneous dispatch_valid → that dispatch is refused. Next cycle a dispatch gets id0 (wrap).
- commit_ready=0 for 5 cycles with head done → commit_valid held, outputs stable, no pointer motion.
- flush with 7 live entries and a same-cycle wb/dispatch → next cycle empty=1, head=tail=0, commit_valid=0; a later wb to id3 is ignored.
- Dispatch with exception_type=0x04 → commit_valid next cycle without any writeback, commit_exception_type=0x04.
